// File: rtl/image_readback_tx.sv
// image_readback_tx
// Reads the input-pixel frame out of the pixel SRAM (1-cycle synchronous read)
// and sends it over a UART TX line as one packet: HEADER, input_neuron pixel
// bytes in address order, then the modulo-256 sum of the pixel bytes.
// Bytes go out back to back as 8N1, LSB first, idle high.
//
// Ports:
//   SNN_CLK   in   clock, rising edge
//   RST_N     in   asynchronous active-low reset; aborts any frame in flight
//   start     in   one-cycle frame request, ignored unless idle
//   mem_en    out  SRAM read enable (one cycle per pixel)
//   mem_addr  out  SRAM read address, holds when mem_en=0
//   mem_dout  in   SRAM read data, valid the cycle after mem_en
//   uart_tx   out  serial line
//   busy      out  frame in progress
//   done      out  one-cycle pulse after the last stop bit
module image_readback_tx #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned input_neuron = 256,
  parameter int unsigned Input_ADDR_W = 12,
  parameter logic [7:0]  HEADER       = 8'hA5
) (
  input  logic                    SNN_CLK,
  input  logic                    RST_N,
  input  logic                    start,
  output logic                    mem_en,
  output logic [Input_ADDR_W-1:0] mem_addr,
  input  logic [7:0]              mem_dout,
  output logic                    uart_tx,
  output logic                    busy,
  output logic                    done
);

  localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0]       BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [Input_ADDR_W-1:0] LAST_IDX  = Input_ADDR_W'(input_neuron - 1);
  localparam logic [3:0]              LAST_DATA = 4'd8;
  localparam logic [3:0]              STOP_BIT  = 4'd9;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_PIX,
    S_CHK,
    S_FIN
  } state_t;

  state_t                  state_q, state_d;
  logic [7:0]              shreg_q, shreg_d;
  logic [BAUD_W-1:0]       baud_q, baud_d;
  logic [3:0]              bit_q, bit_d;
  logic [Input_ADDR_W-1:0] idx_q, idx_d;
  logic [7:0]              csum_q, csum_d;
  logic [7:0]              hold_q, hold_d;
  logic                    rd_pend_q, rd_pend_d;
  logic                    mem_en_d;
  logic [Input_ADDR_W-1:0] mem_addr_d;
  logic                    uart_tx_d;
  logic                    busy_d;
  logic                    done_d;

  // State and datapath registers; uart_tx resets high so an aborted frame
  // leaves the line idle immediately.
  always_ff @(posedge SNN_CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= S_IDLE;
      shreg_q   <= '0;
      baud_q    <= '0;
      bit_q     <= '0;
      idx_q     <= '0;
      csum_q    <= '0;
      hold_q    <= '0;
      rd_pend_q <= 1'b0;
      mem_en    <= 1'b0;
      mem_addr  <= '0;
      uart_tx   <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      baud_q    <= baud_d;
      bit_q     <= bit_d;
      idx_q     <= idx_d;
      csum_q    <= csum_d;
      hold_q    <= hold_d;
      rd_pend_q <= rd_pend_d;
      mem_en    <= mem_en_d;
      mem_addr  <= mem_addr_d;
      uart_tx   <= uart_tx_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

  // Next-state, serializer and prefetch logic.
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    baud_d     = baud_q;
    bit_d      = bit_q;
    idx_d      = idx_q;
    csum_d     = csum_q;
    hold_d     = hold_q;
    rd_pend_d  = mem_en;
    mem_en_d   = 1'b0;
    mem_addr_d = mem_addr;
    uart_tx_d  = uart_tx;
    busy_d     = busy;
    done_d     = 1'b0;

    // Read data arrives the cycle after mem_en; bank it and fold into the sum.
    if (rd_pend_q) begin
      hold_d = mem_dout;
      csum_d = csum_q + mem_dout;
    end

    case (state_q)
      S_IDLE: begin
        uart_tx_d = 1'b1;
        busy_d    = 1'b0;
        if (start) begin
          state_d   = S_HDR;
          shreg_d   = HEADER;
          csum_d    = '0;
          idx_d     = '0;
          baud_d    = '0;
          bit_d     = '0;
          busy_d    = 1'b1;
          uart_tx_d = 1'b0;
        end
      end

      S_HDR, S_PIX, S_CHK: begin
        if (baud_q == BAUD_LAST) begin
          baud_d = '0;
          if (bit_q == STOP_BIT) begin
            // End of stop bit: next byte starts on the following edge.
            bit_d     = '0;
            uart_tx_d = 1'b0;
            case (state_q)
              S_HDR: begin
                state_d = S_PIX;
                shreg_d = hold_q;
                idx_d   = '0;
              end
              S_PIX: begin
                if (idx_q == LAST_IDX) begin
                  state_d = S_CHK;
                  shreg_d = csum_q;
                end else begin
                  shreg_d = hold_q;
                  idx_d   = idx_q + Input_ADDR_W'(1);
                end
              end
              default: begin
                state_d   = S_FIN;
                uart_tx_d = 1'b1;
                busy_d    = 1'b0;
                done_d    = 1'b1;
              end
            endcase
          end else begin
            bit_d = bit_q + 4'd1;
            if (bit_q == LAST_DATA) begin
              // Entering the stop bit: fetch the pixel that follows this byte.
              uart_tx_d = 1'b1;
              if (state_q == S_HDR) begin
                mem_en_d   = 1'b1;
                mem_addr_d = '0;
              end else if (state_q == S_PIX && idx_q != LAST_IDX) begin
                mem_en_d   = 1'b1;
                mem_addr_d = idx_q + Input_ADDR_W'(1);
              end
            end else begin
              uart_tx_d = shreg_q[bit_q[2:0]];
            end
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end

      S_FIN: begin
        state_d   = S_IDLE;
        uart_tx_d = 1'b1;
        busy_d    = 1'b0;
      end

      default: begin
        state_d   = S_IDLE;
        uart_tx_d = 1'b1;
        busy_d    = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_image_readback_tx.sv
// Testbench for image_readback_tx: a small instance (4 pixels) and a full-size
// instance (256 pixels), both at 4 clocks per bit. Expected bytes are queued
// when a frame is requested; a UART monitor decodes the line and pops/compares.
module tb_image_readback_tx;

  localparam int unsigned CPB = 4;
  localparam int unsigned NS  = 4;
  localparam int unsigned NB  = 256;
  localparam int unsigned AW  = 12;
  localparam logic [7:0]  HDR = 8'hA5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start_r;
  logic          sel_big;
  logic          start_s, start_b;
  logic          en_s, en_b, tx_s, tx_b, busy_s, busy_b, done_s, done_b;
  logic [AW-1:0] addr_s, addr_b;
  logic [7:0]    dout_s, dout_b;
  logic          tx_m, busy_m, done_m, en_m;
  logic [AW-1:0] addr_m;

  logic [7:0]    mem [0:4095];
  logic [7:0]    exp_q[$];
  logic [AW-1:0] addr_log[$];
  int            n_vec = 0;
  int            n_err = 0;

  always #5 clk = ~clk;

  assign start_s = start_r & ~sel_big;
  assign start_b = start_r & sel_big;
  assign tx_m    = sel_big ? tx_b   : tx_s;
  assign busy_m  = sel_big ? busy_b : busy_s;
  assign done_m  = sel_big ? done_b : done_s;
  assign en_m    = sel_big ? en_b   : en_s;
  assign addr_m  = sel_big ? addr_b : addr_s;

  image_readback_tx #(.CLKS_PER_BIT(CPB), .input_neuron(NS), .Input_ADDR_W(AW), .HEADER(HDR)) dut (
    .SNN_CLK(clk), .RST_N(rst_n), .start(start_s), .mem_en(en_s), .mem_addr(addr_s),
    .mem_dout(dout_s), .uart_tx(tx_s), .busy(busy_s), .done(done_s)
  );

  image_readback_tx #(.CLKS_PER_BIT(CPB), .input_neuron(NB), .Input_ADDR_W(AW), .HEADER(HDR)) dut_big (
    .SNN_CLK(clk), .RST_N(rst_n), .start(start_b), .mem_en(en_b), .mem_addr(addr_b),
    .mem_dout(dout_b), .uart_tx(tx_b), .busy(busy_b), .done(done_b)
  );

  // Synchronous-read SRAM models sharing one array.
  always @(posedge clk) begin
    if (en_s) dout_s <= mem[addr_s];
    if (en_b) dout_b <= mem[addr_b];
  end

  // Log every read address (one entry per enabled cycle).
  always @(negedge clk) begin
    if (en_m) addr_log.push_back(addr_m);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference frame: header, pixels in address order, sum of pixels mod 256.
  task automatic push_exp(input int n);
    int sum;
    sum = 0;
    addr_log.delete();
    exp_q.push_back(HDR);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(mem[i]);
      sum += int'(mem[i]);
    end
    exp_q.push_back(8'(sum % 256));
  endtask

  task automatic kick();
    @(negedge clk);
    start_r = 1'b1;
    @(posedge clk);
    #1;
    start_r = 1'b0;
    chk("busy_rise", 32'(busy_m), 1);
    chk("header_start_bit", 32'(tx_m), 0);
  endtask

  // Counts edges from the accepted start until done; optional stray starts.
  task automatic wait_done(input int exp_cyc, input int s1, input int s2);
    int cyc;
    cyc = 0;
    while (done_m !== 1'b1 && cyc < exp_cyc + 64) begin
      @(posedge clk);
      #1;
      cyc++;
      start_r = (cyc == s1) || (cyc == s2);
    end
    start_r = 1'b0;
    chk("frame_cycles", 32'(cyc), 32'(exp_cyc));
    chk("busy_fall_with_done", 32'(busy_m), 0);
  endtask

  task automatic check_addrs(input int n);
    chk("addr_count", 32'(addr_log.size()), 32'(n));
    for (int i = 0; i < addr_log.size() && i < n; i++)
      chk("addr_seq", 32'(addr_log[i]), 32'(i));
    chk("addr_hold", 32'(addr_m), 32'(n - 1));
  endtask

  task automatic finish_idle(input int n);
    chk("bytes_drained", 32'(exp_q.size()), 0);
    check_addrs(n);
    @(posedge clk);
    #1;
    chk("done_one_cycle", 32'(done_m), 0);
    chk("idle_busy", 32'(busy_m), 0);
    chk("idle_tx", 32'(tx_m), 1);
  endtask

  // UART monitor: each bit must hold for all CPB samples; pops expected bytes.
  initial begin : monitor
    logic [9:0] bits;
    logic       ok;
    logic       ab;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && tx_m === 1'b0) begin
        ok = 1'b1;
        ab = 1'b0;
        bits = '0;
        for (int b = 0; b < 10; b++) begin
          for (int s = 0; s < int'(CPB); s++) begin
            if (b != 0 || s != 0) @(negedge clk);
            if (rst_n !== 1'b1) begin
              ab = 1'b1;
              break;
            end
            if (s == 0) bits[b] = tx_m;
            else if (tx_m !== bits[b]) ok = 1'b0;
          end
          if (ab) break;
        end
        if (!ab) begin
          chk("framing", 32'(ok && bits[0] == 1'b0 && bits[9] == 1'b1), 1);
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_byte: got 0x%0h, want none", bits[8:1]);
          end else begin
            chk("byte", 32'(bits[8:1]), 32'(exp_q.pop_front()));
          end
        end
      end
    end
  end

  initial begin : main
    int dev;
    start_r = 1'b0;
    sel_big = 1'b0;
    rst_n   = 1'b0;
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;

    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", 32'(tx_m), 1);
    chk("rst_busy", 32'(busy_m), 0);
    chk("rst_done", 32'(done_m), 0);
    chk("rst_en", 32'(en_m), 0);
    chk("rst_addr", 32'(addr_m), 0);
    chk("rst_tx_big", 32'(tx_b), 1);
    @(negedge clk);
    rst_n = 1'b1;
    dev = 0;
    repeat (1000) begin
      @(posedge clk);
      #1;
      if (tx_m !== 1'b1 || busy_m !== 1'b0 || done_m !== 1'b0 || en_m !== 1'b0 || addr_m !== '0)
        dev++;
    end
    chk("idle_after_reset", 32'(dev), 0);

    // Basic frame.
    mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'h03; mem[3] = 8'hFC;
    push_exp(NS);
    kick();
    wait_done(240, -1, -1);
    finish_idle(NS);

    // Stray starts while busy, start in FIN ignored, start one cycle later accepted.
    push_exp(NS);
    kick();
    wait_done(240, 10, 100);
    chk("bytes_drained", 32'(exp_q.size()), 0);
    check_addrs(NS);
    push_exp(NS);
    start_r = 1'b1;
    @(posedge clk);
    #1;
    chk("fin_start_ignored", 32'(busy_m), 0);
    chk("done_one_cycle", 32'(done_m), 0);
    @(posedge clk);
    #1;
    start_r = 1'b0;
    chk("chain_busy", 32'(busy_m), 1);
    chk("chain_start_bit", 32'(tx_m), 0);
    wait_done(240, -1, -1);
    finish_idle(NS);

    // Reset during data bit d2 of pixel 1 (byte 2), then a full new frame.
    push_exp(NS);
    kick();
    repeat (92) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_bytes_left", 32'(exp_q.size()), 4);
    chk("abort_tx", 32'(tx_m), 1);
    chk("abort_busy", 32'(busy_m), 0);
    chk("abort_done", 32'(done_m), 0);
    chk("abort_en", 32'(en_m), 0);
    chk("abort_addr", 32'(addr_m), 0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    push_exp(NS);
    kick();
    wait_done(240, -1, -1);
    finish_idle(NS);

    // New SRAM contents; checksum must restart from zero.
    mem[0] = 8'h00; mem[1] = 8'h00; mem[2] = 8'h00; mem[3] = 8'h80;
    push_exp(NS);
    kick();
    wait_done(240, -1, -1);
    finish_idle(NS);

    // Randomized pixel data with random stray starts and idle gaps.
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < int'(NS); i++) mem[i] = 8'($urandom_range(0, 255));
      push_exp(NS);
      kick();
      wait_done(240, int'($urandom_range(1, 230)), int'($urandom_range(1, 230)));
      finish_idle(NS);
      repeat ($urandom_range(0, 20)) @(posedge clk);
    end

    // Full-size frame, all pixels FF.
    sel_big = 1'b1;
    for (int i = 0; i < int'(NB); i++) mem[i] = 8'hFF;
    push_exp(NB);
    kick();
    wait_done(10320, -1, -1);
    finish_idle(NB);

    repeat (5) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
